fifo_pwmr_win: RTL and testbench

//  Parallel-write, multi-reader FIFO with per-reader variable-length pop and read window.
//  One writer pushes WR_NUM words per accepted cycle; RD_NUM readers each own a read pointer.

---
 rtl/fifo_pwmr_win_pkg.sv | 18 +
 rtl/fifo_pwmr_win_rdport.sv | 82 ++++++++
 rtl/fifo_pwmr_win.sv | 125 ++++++++++++
 tb/tb_fifo_pwmr_win.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pwmr_win_pkg.sv
// Shared sizing helpers and default geometry for the parallel-write, multi-reader windowed FIFO.
package fifo_pwmr_win_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_WR_NUM     = 4;
  localparam int DEF_RD_NUM     = 2;
  localparam int DEF_WIN        = 4;

  // Ceiling log2; c_log_2(WIN+1) gives the bits needed to encode 0..WIN.
  function automatic int c_log_2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_pwmr_win_rdport.sv
// One reader of fifo_pwmr_win: read pointer, occupancy, pop acceptance and the WIN-word window mux.
// Optional sticky pop_err when FIFO_PWMR_ERR_EN is defined.
module fifo_pwmr_win_rdport
  import fifo_pwmr_win_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WIN        = DEF_WIN,
  parameter int CNT_W      = ADDR_WIDTH + 1,
  parameter int POP_W      = c_log_2(WIN + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  Reset,
  input  logic [CNT_W-1:0]                      wr_ptr,
  input  logic [DATA_WIDTH*(1<<ADDR_WIDTH)-1:0] mem_rd,
  input  logic [POP_W-1:0]                      pop_num,
  output logic [DATA_WIDTH*WIN-1:0]             data_out,
  output logic [WIN-1:0]                        win_vld,
  output logic [CNT_W-1:0]                      count,
  output logic                                  empty
`ifdef FIFO_PWMR_ERR_EN
  ,
  output logic                                  pop_err
`endif
);

  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  pop_acc;
  logic [ADDR_WIDTH-1:0] win_addr;

  // Pop is judged against the occupancy seen before this cycle's push lands.
  always_comb begin
    count    = wr_ptr - rd_ptr_q;
    empty    = (count == '0);
    pop_acc  = (CNT_W'(pop_num) <= count);
    rd_ptr_d = rd_ptr_q;
    if (Reset) begin
      rd_ptr_d = '0;
    end else if (pop_acc) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(pop_num);
    end
  end

  always_comb begin
    data_out = '0;
    win_vld  = '0;
    win_addr = '0;
    for (int w = 0; w < WIN; w++) begin
      win_addr = rd_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(w);
      data_out[DATA_WIDTH*w +: DATA_WIDTH] = mem_rd[DATA_WIDTH*win_addr +: DATA_WIDTH];
      win_vld[w] = (count > CNT_W'(w));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef FIFO_PWMR_ERR_EN
  logic pop_err_q, pop_err_d;

  always_comb begin
    pop_err_d = Reset ? 1'b0 : (pop_err_q | ~pop_acc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_err_q <= 1'b0;
    end else begin
      pop_err_q <= pop_err_d;
    end
  end

  assign pop_err = pop_err_q;
`endif

endmodule

// File: rtl/fifo_pwmr_win.sv
// Parallel-write (WR_NUM words), RD_NUM-reader FIFO; each reader sees a WIN-word combinational window.
// Define FIFO_PWMR_ERR_EN to add sticky pop_err/push_err flags.
module fifo_pwmr_win
  import fifo_pwmr_win_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WR_NUM     = DEF_WR_NUM,
  parameter int RD_NUM     = DEF_RD_NUM,
  parameter int WIN        = DEF_WIN,
  parameter int CNT_W      = ADDR_WIDTH + 1,
  parameter int POP_W      = c_log_2(WIN + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            Reset,
  input  logic                            push,
  output logic                            push_rdy,
  input  logic [DATA_WIDTH*WR_NUM-1:0]    data_in,
  input  logic [POP_W*RD_NUM-1:0]         pop_num,
  output logic [DATA_WIDTH*WIN*RD_NUM-1:0] data_out,
  output logic [WIN*RD_NUM-1:0]           win_vld,
  output logic [CNT_W*RD_NUM-1:0]         count,
  output logic [RD_NUM-1:0]               empty
`ifdef FIFO_PWMR_ERR_EN
  ,
  output logic [RD_NUM-1:0]               pop_err,
  output logic                            push_err
`endif
);

  localparam int               RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] WR_C      = CNT_W'(WR_NUM);

  logic [DATA_WIDTH-1:0]           mem_q [RAM_DEPTH];
  logic [DATA_WIDTH*RAM_DEPTH-1:0] mem_rd;
  logic [CNT_W-1:0]                wr_ptr_q, wr_ptr_d;
  logic [RD_NUM-1:0]               rd_room;
  logic                            push_acc;

  // The slowest reader gates the writer: every reader must have room for a full push.
  always_comb begin
    rd_room = '0;
    for (int i = 0; i < RD_NUM; i++) begin
      rd_room[i] = ((DEPTH_C - count[CNT_W*i +: CNT_W]) >= WR_C);
    end
    push_rdy = &rd_room;
    push_acc = push & push_rdy & ~Reset;
    wr_ptr_d = wr_ptr_q;
    if (Reset) begin
      wr_ptr_d = '0;
    end else if (push_acc) begin
      wr_ptr_d = wr_ptr_q + WR_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is not reset; unread words are masked by win_vld.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      for (int k = 0; k < WR_NUM; k++) begin
        mem_q[wr_ptr_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k)] <= data_in[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    mem_rd = '0;
    for (int d = 0; d < RAM_DEPTH; d++) begin
      mem_rd[DATA_WIDTH*d +: DATA_WIDTH] = mem_q[d];
    end
  end

  for (genvar i = 0; i < RD_NUM; i++) begin : g_rd
    fifo_pwmr_win_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIN        (WIN),
      .CNT_W      (CNT_W),
      .POP_W      (POP_W)
    ) u_rdport (
      .clk      (clk),
      .rst_n    (rst_n),
      .Reset    (Reset),
      .wr_ptr   (wr_ptr_q),
      .mem_rd   (mem_rd),
      .pop_num  (pop_num[POP_W*i +: POP_W]),
      .data_out (data_out[DATA_WIDTH*WIN*i +: DATA_WIDTH*WIN]),
      .win_vld  (win_vld[WIN*i +: WIN]),
      .count    (count[CNT_W*i +: CNT_W]),
      .empty    (empty[i])
`ifdef FIFO_PWMR_ERR_EN
      ,
      .pop_err  (pop_err[i])
`endif
    );
  end

`ifdef FIFO_PWMR_ERR_EN
  logic push_err_q, push_err_d;

  always_comb begin
    push_err_d = Reset ? 1'b0 : (push_err_q | (push & ~push_rdy));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_err_q <= 1'b0;
    end else begin
      push_err_q <= push_err_d;
    end
  end

  assign push_err = push_err_q;
`endif

endmodule

// File: tb/tb_fifo_pwmr_win.sv
// Bench for fifo_pwmr_win: directed vector table, then random traffic against per-reader queue model.
module tb_fifo_pwmr_win;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int WR    = 4;
  localparam int RD    = 2;
  localparam int WIN   = 4;
  localparam int CW    = AW + 1;
  localparam int PW    = 3;
  localparam int DEPTH = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  Reset = 1'b0;
  logic                  push = 1'b0;
  logic                  push_rdy;
  logic [DW*WR-1:0]      data_in = '0;
  logic [PW*RD-1:0]      pop_num = '0;
  logic [DW*WIN*RD-1:0]  data_out;
  logic [WIN*RD-1:0]     win_vld;
  logic [CW*RD-1:0]      count;
  logic [RD-1:0]         empty;
`ifdef FIFO_PWMR_ERR_EN
  logic [RD-1:0]         pop_err;
  logic                  push_err;
`endif

  fifo_pwmr_win dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Reset    (Reset),
    .push     (push),
    .push_rdy (push_rdy),
    .data_in  (data_in),
    .pop_num  (pop_num),
    .data_out (data_out),
    .win_vld  (win_vld),
    .count    (count),
    .empty    (empty)
`ifdef FIFO_PWMR_ERR_EN
    ,
    .pop_err  (pop_err),
    .push_err (push_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: each reader owns a queue of the words it has not yet consumed.
  logic [DW-1:0] mq [RD][$];
  int            m_pop_err [RD];
  int            m_push_err;
  int            n_pass = 0;
  int            n_chk  = 0;

  typedef struct {
    int rst; int psh; int base; int p0; int p1;
    int c0;  int c1;  int rdy;  int w0; int w1;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(input int rst, input int psh, input int base, input int p0,
                              input int p1, input int c0, input int c1, input int rdy,
                              input int w0, input int w1);
    vec_t v;
    v.rst = rst; v.psh = psh; v.base = base; v.p0 = p0; v.p1 = p1;
    v.c0 = c0; v.c1 = c1; v.rdy = rdy; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  function automatic logic [DW*WR-1:0] mkdata(input int base);
    logic [DW*WR-1:0] d;
    d = '0;
    for (int k = 0; k < WR; k++) d[DW*k +: DW] = DW'(base + k);
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_update(input int rst, input int psh, input logic [DW*WR-1:0] d,
                              input int p0, input int p1);
    int p [RD];
    int rdy;
    logic [DW-1:0] junk;
    p[0] = p0;
    p[1] = p1;
    rdy  = 1;
    if (rst != 0) begin
      for (int i = 0; i < RD; i++) begin
        mq[i].delete();
        m_pop_err[i] = 0;
      end
      m_push_err = 0;
    end else begin
      for (int i = 0; i < RD; i++) if (mq[i].size() > DEPTH - WR) rdy = 0;
      for (int i = 0; i < RD; i++) begin
        if (p[i] <= mq[i].size()) begin
          for (int k = 0; k < p[i]; k++) junk = mq[i].pop_front();
        end else begin
          m_pop_err[i] = 1;
        end
      end
      if (psh != 0) begin
        if (rdy != 0) begin
          for (int i = 0; i < RD; i++)
            for (int k = 0; k < WR; k++) mq[i].push_back(d[DW*k +: DW]);
        end else begin
          m_push_err = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int rdy;
    int sz;
    rdy = 1;
    for (int i = 0; i < RD; i++) if (mq[i].size() > DEPTH - WR) rdy = 0;
    chk({tag, " push_rdy"}, int'(push_rdy), rdy);
    for (int i = 0; i < RD; i++) begin
      sz = mq[i].size();
      chk($sformatf("%s count%0d", tag, i), int'(count[CW*i +: CW]), sz);
      chk($sformatf("%s empty%0d", tag, i), int'(empty[i]), (sz == 0) ? 1 : 0);
      for (int w = 0; w < WIN; w++) begin
        chk($sformatf("%s win_vld%0d[%0d]", tag, i, w), int'(win_vld[WIN*i + w]), (sz > w) ? 1 : 0);
        if (sz > w)
          chk($sformatf("%s data%0d[%0d]", tag, i, w),
              int'(data_out[(WIN*i + w)*DW +: DW]), int'(mq[i][w]));
      end
`ifdef FIFO_PWMR_ERR_EN
      chk($sformatf("%s pop_err%0d", tag, i), int'(pop_err[i]), m_pop_err[i]);
`endif
    end
`ifdef FIFO_PWMR_ERR_EN
    chk({tag, " push_err"}, int'(push_err), m_push_err);
`endif
  endtask

  task automatic step(input int rst, input int psh, input logic [DW*WR-1:0] d,
                      input int p0, input int p1, input string tag);
    Reset   = (rst != 0);
    push    = (psh != 0);
    data_in = d;
    pop_num = {PW'(p1), PW'(p0)};
    @(posedge clk);
    model_update(rst, psh, d, p0, p1);
    #1;
    Reset   = 1'b0;
    push    = 1'b0;
    pop_num = '0;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  v;
    string tag;
    int    rst, psh, p0, p1;

    for (int i = 0; i < RD; i++) m_pop_err[i] = 0;
    m_push_err = 0;

    // Fill to full, then drop a push on the full FIFO.
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, -1, -1));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0, 1, 4*k, 0, 0, 4*(k+1), 4*(k+1), (k < 7) ? 1 : 0, 0, 0));
    vt.push_back(mk(0, 1, 200, 0, 0, 32, 32, 0, 0, 0));
    // Drain to pointer 30, then push so the window straddles the top of memory.
    for (int k = 1; k < 8; k++)
      vt.push_back(mk(0, 0, 0, 4, 4, 32 - 4*k, 32 - 4*k, 1, 4*k, 4*k));
    vt.push_back(mk(0, 0, 0, 2, 2, 2, 2, 1, 30, 30));
    vt.push_back(mk(0, 1, 32, 0, 0, 6, 6, 1, 30, 30));
    // Sync Reset wins over simultaneous push and pop.
    vt.push_back(mk(1, 1, 99, 1, 1, 0, 0, 1, -1, -1));
    // Variable-length pops.
    vt.push_back(mk(0, 1, 0, 0, 0, 4, 4, 1, 0, 0));
    vt.push_back(mk(0, 1, 4, 0, 0, 8, 8, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 3, 0, 5, 8, 1, 3, 0));
    vt.push_back(mk(0, 0, 0, 4, 0, 1, 8, 1, 7, 0));
    // Over-long pops are rejected without moving the pointer.
    vt.push_back(mk(0, 0, 0, 0, 4, 1, 4, 1, 7, 4));
    vt.push_back(mk(0, 0, 0, 0, 2, 1, 2, 1, 7, 6));
    vt.push_back(mk(0, 0, 0, 0, 3, 1, 2, 1, 7, 6));
    vt.push_back(mk(0, 0, 0, 2, 0, 1, 2, 1, 7, 6));
    vt.push_back(mk(0, 0, 0, 1, 2, 0, 0, 1, -1, -1));
    // Simultaneous push and pop near full; slow reader gates the writer.
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, -1, -1));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(0, 1, 4*k, 0, 0, 4*(k+1), 4*(k+1), (k < 7) ? 1 : 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 4, 0, 28, 32, 0, 4, 0));
    vt.push_back(mk(0, 0, 0, 0, 3, 28, 29, 0, 4, 3));
    vt.push_back(mk(0, 0, 0, 0, 1, 28, 28, 1, 4, 4));
    vt.push_back(mk(0, 1, 32, 4, 0, 28, 32, 0, 8, 4));
    vt.push_back(mk(0, 1, 40, 4, 0, 24, 32, 0, 12, 4));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, -1, -1));

    // Power-on reset, checked while rst_n is still low.
    #1 rst_n = 1'b0;
    #2 check_all("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < vt.size(); n++) begin
      v   = vt[n];
      tag = $sformatf("vec%0d", n);
      step(v.rst, v.psh, mkdata(v.base), v.p0, v.p1, tag);
      chk({tag, " tbl count0"}, int'(count[0 +: CW]), v.c0);
      chk({tag, " tbl count1"}, int'(count[CW +: CW]), v.c1);
      chk({tag, " tbl push_rdy"}, int'(push_rdy), v.rdy);
      if (v.w0 >= 0) chk({tag, " tbl win0 head"}, int'(data_out[0 +: DW]), v.w0);
      if (v.w1 >= 0) chk({tag, " tbl win1 head"}, int'(data_out[DW*WIN +: DW]), v.w1);
    end

    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0) ? 1 : 0;
      psh = ($urandom_range(0, 9) < 6) ? 1 : 0;
      p0  = $urandom_range(0, WIN);
      p1  = $urandom_range(0, 3);
      step(rst, psh, DW*WR'($urandom), p0, p1, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a cycle clears everything immediately.
    step(0, 1, mkdata(77), 0, 0, "pre_arst");
    #3 rst_n = 1'b0;
    model_update(1, 0, '0, 0, 0);
    #1 check_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, mkdata(50), 0, 0, "post_arst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
